haze_frame_ctrl: RTL
====================

HAZE_FRAME_CTRL -- requirements
Module: haze_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640, active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480, active lines per frame.
REQ-003 SHALL have parameter A_DEFAULT, default 8'd220, atmospheric light used before the first valid A.
REQ-004 SHALL have parameter A_MIN, default 8'd16, lower clamp on the latched A (avoids near-zero divisor downstream).
REQ-005 SHALL have parameter A_TIMEOUT, default 4096, cycles allowed from end of frame to a_done.
REQ-006 Ports, in this order:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- pre_frame_vsync/href/clken  in  1 each  source stream; vsync is high for the whole frame.
- cfg_enable  in  1  run request.
- cfg_bypass  in  1  bypass request.
- cfg_a_force  in  1  use cfg_a_value instead of the measured A.
- cfg_a_value  in  8  forced A.
- err_clr  in  1  clears the sticky error flags.
- a_result  in  8  measured A, from the A-estimation stage.
- a_done  in  1  one-cycle strobe; a_result is valid in that cycle.
- gate_frame_vsync/href/clken  out  1 each  gated stream into the dehaze pipeline.
- a_value  out  8  A for the current frame.
- bypass_sel  out  1  output mux select, raw vs dehazed.
- busy  out  1  high in every state except IDLE.
- frame_cnt  out  16  completed frames.
- geom_err  out  1  sticky; frame size mismatch.
- a_timeout  out  1  sticky; A not delivered in time.

Function
REQ-007 Edge detection SHALL register vsync (vsync_d); SOF = vsync & ~vsync_d; EOF = ~vsync & vsync_d.
REQ-008 FSM states SHALL be IDLE, ARM, WAIT_SOF, RUN, WAIT_A.
REQ-009 IDLE SHALL go to ARM when cfg_enable=1.
REQ-010 ARM SHALL go to WAIT_SOF in the first cycle vsync=0, so the block never joins mid-frame.
REQ-011 WAIT_SOF SHALL go to RUN on SOF; it SHALL go to IDLE if cfg_enable=0 in a cycle without SOF.
REQ-012 RUN SHALL go to WAIT_A on EOF; cfg_enable=0 during RUN SHALL take effect only after EOF.
REQ-013 WAIT_A SHALL go to WAIT_SOF on a_done, or on the A_TIMEOUT-th cycle without a_done (setting a_timeout).
REQ-014 SOF arriving in WAIT_A SHALL go directly to RUN and set a_timeout.
REQ-015 If a_done and SOF coincide in WAIT_A, a_done SHALL be latched first, then the FSM enters RUN with no error.
REQ-016 In WAIT_A, if cfg_enable=0 when leaving, the FSM SHALL go to IDLE instead of WAIT_SOF.
REQ-017 a_done SHALL latch max(a_result, A_MIN) into a_meas and set a_meas_valid; a_done outside WAIT_A SHALL be ignored.
REQ-018 Gate output timing:
- gate_open = (state==RUN) | (state==WAIT_SOF & SOF), plus the EOF cycle itself.
- gate_x(t+1) = pre_x(t) & gate_open(t), for each of vsync/href/clken.
- Latency SHALL be exactly 1 cycle; with the gate closed, all gate outputs are 0.
REQ-019 a_value and bypass_sel SHALL update only in the SOF cycle that enters RUN, and hold for the whole frame.
- a_value = cfg_a_force ? cfg_a_value : (a_meas_valid ? a_meas : A_DEFAULT).
- bypass_sel = cfg_bypass.
REQ-020 Geometry counters:
- In RUN, count gated clken (width ceil(log2(IMG_W*IMG_H+1))) and href rising edges (line count).
- At EOF, set geom_err if pixels != IMG_W*IMG_H or lines != IMG_H.
- Clear both counters at SOF.
REQ-021 frame_cnt SHALL increment at each EOF in RUN and wrap from 16'hFFFF to 0.
REQ-022 err_clr SHALL clear geom_err and a_timeout; a set event in the same cycle SHALL win.

Reset
REQ-023 On rst=1, asynchronously:
- state = IDLE.
- all gate outputs = 0.
- a_value = A_DEFAULT; a_meas_valid = 0.
- bypass_sel, busy, geom_err, a_timeout = 0.
- frame_cnt and all counters = 0.
REQ-024 Reset asserted mid-frame SHALL close the gate immediately; after release, the block SHALL re-enter only via ARM, never mid-frame.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding and A_DEFAULT/A_MIN defaults.
REQ-026 One sub-module, haze_frame_geom_chk (pixel/line counting and compare), is natural; all else SHALL stay flat.

Verification
REQ-027 cfg_enable=1 raised mid-frame of a 640x480 stream -> gate stays closed until the next SOF; first gated clken exactly 1 cycle after the source clken.
REQ-028 a_result=8'd5 with a_done in WAIT_A -> next frame a_value=8'd16; with cfg_a_force=1 and cfg_a_value=8'd200 -> a_value=200.
REQ-029 No a_done for 4096 cycles after EOF -> a_timeout=1 and a_value keeps the previous value; err_clr -> 0.
REQ-030 Frame with 479 lines -> geom_err=1 at EOF, frame_cnt increments.
REQ-031 cfg_bypass toggled mid-frame -> bypass_sel changes only at the next SOF.
REQ-032 a_done coincident with SOF -> new A applied to that frame, a_timeout stays 0; rst pulse mid-frame -> all gate outputs 0 the same cycle.

Source files
------------

// File: rtl/haze_frame_ctrl_pkg.sv
// Shared definitions for the haze frame controller.
// Holds the FSM state encoding, the atmospheric-light defaults and a clamp
// helper used when latching the measured A value.
package haze_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_WAIT_SOF = 3'd2,
        ST_RUN      = 3'd3,
        ST_WAIT_A   = 3'd4
    } state_e;

    localparam logic [7:0] HFC_A_DEFAULT = 8'd220;
    localparam logic [7:0] HFC_A_MIN     = 8'd16;

    // Raise a value to a floor (max of the two).
    function automatic logic [7:0] clamp_floor(input logic [7:0] val, input logic [7:0] floor_v);
        return (val < floor_v) ? floor_v : val;
    endfunction

endpackage

// File: rtl/haze_frame_geom_chk.sv
// Frame geometry checker.
// Counts gated pixels (clken) and line starts (href rising edges) for one
// frame and flags a size mismatch in the frame's closing cycle.
// Ports:
//   clk, rst        clock, async active-high reset
//   sof_i           start of frame; restarts both counters
//   eof_i           closing cycle of a frame being checked
//   en_i            gate open; only gated samples are counted
//   href_i, clken_i source line / pixel qualifiers
//   frame_bad_c_o   combinational mismatch pulse, valid with eof_i
module haze_frame_geom_chk #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic clk,
    input  logic rst,
    input  logic sof_i,
    input  logic eof_i,
    input  logic en_i,
    input  logic href_i,
    input  logic clken_i,
    output logic frame_bad_c_o
);

    localparam int unsigned PIX_W  = $clog2(IMG_W * IMG_H + 1);
    localparam int unsigned LINE_W = $clog2(IMG_H + 1);

    logic              href_q;
    logic [PIX_W-1:0]  pix_q, pix_d, pix_base;
    logic [LINE_W-1:0] line_q, line_d, line_base;
    logic              pix_inc, line_inc;

    assign pix_inc  = en_i & clken_i;
    assign line_inc = en_i & href_i & ~href_q;

    // Counters restart on SOF and saturate so an oversized frame cannot wrap
    // back onto the expected size.
    always_comb begin
        pix_base  = sof_i ? '0 : pix_q;
        line_base = sof_i ? '0 : line_q;
        pix_d     = pix_base;
        line_d    = line_base;
        if (pix_inc && (pix_base != '1)) begin
            pix_d = pix_base + PIX_W'(1);
        end
        if (line_inc && (line_base != '1)) begin
            line_d = line_base + LINE_W'(1);
        end
    end

    // Compare including the current cycle's contribution.
    assign frame_bad_c_o = eof_i & ((pix_d != PIX_W'(IMG_W * IMG_H)) |
                                    (line_d != LINE_W'(IMG_H)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            href_q <= 1'b0;
            pix_q  <= '0;
            line_q <= '0;
        end else begin
            href_q <= href_i;
            pix_q  <= pix_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/haze_frame_ctrl.sv
// Frame-level controller for the dehaze pipeline.
// Gates the source video stream so the pipeline only ever sees whole frames,
// selects the atmospheric light A per frame, and tracks frame geometry and
// A-delivery errors.
// Ports:
//   clk, rst                      clock, async active-high reset
//   pre_frame_vsync/href/clken    source stream (vsync high for whole frame)
//   cfg_enable, cfg_bypass        run / bypass requests
//   cfg_a_force, cfg_a_value      override of the measured A
//   err_clr                       clears sticky error flags
//   a_result, a_done              measured A and its valid strobe
//   gate_frame_vsync/href/clken   gated stream, one cycle latency
//   a_value, bypass_sel           per-frame A and output mux select
//   busy, frame_cnt               status
//   geom_err, a_timeout           sticky error flags
module haze_frame_ctrl
    import haze_frame_ctrl_pkg::*;
#(
    parameter int unsigned IMG_W     = 640,
    parameter int unsigned IMG_H     = 480,
    parameter logic [7:0]  A_DEFAULT = HFC_A_DEFAULT,
    parameter logic [7:0]  A_MIN     = HFC_A_MIN,
    parameter int unsigned A_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pre_frame_vsync,
    input  logic        pre_frame_href,
    input  logic        pre_frame_clken,
    input  logic        cfg_enable,
    input  logic        cfg_bypass,
    input  logic        cfg_a_force,
    input  logic [7:0]  cfg_a_value,
    input  logic        err_clr,
    input  logic [7:0]  a_result,
    input  logic        a_done,
    output logic        gate_frame_vsync,
    output logic        gate_frame_href,
    output logic        gate_frame_clken,
    output logic [7:0]  a_value,
    output logic        bypass_sel,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        geom_err,
    output logic        a_timeout
);

    localparam int unsigned TMR_W = $clog2(A_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic              vsync_q;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [7:0]        a_meas_q, a_meas_d;
    logic              a_meas_valid_q, a_meas_valid_d;
    logic [7:0]        a_value_q, a_value_d;
    logic              bypass_q, bypass_d;
    logic              gate_vs_q, gate_hr_q, gate_ck_q;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              geom_err_q, geom_err_d;
    logic              a_to_q, a_to_d;
    logic              busy_q, busy_d;

    logic sof_c, eof_c, enter_run_c, gate_open_c, run_eof_c;
    logic timeout_c, late_sof_c, geom_bad_c;

    assign sof_c = pre_frame_vsync & ~vsync_q;
    assign eof_c = ~pre_frame_vsync & vsync_q;

    // A new frame may start from WAIT_SOF or straight out of WAIT_A.
    assign enter_run_c = sof_c & ((state_q == ST_WAIT_SOF) | (state_q == ST_WAIT_A));
    assign gate_open_c = (state_q == ST_RUN) | enter_run_c;
    assign run_eof_c   = eof_c & (state_q == ST_RUN);

    // Next-state logic, A-wait timer and A capture.
    always_comb begin
        state_d        = state_q;
        tmr_d          = tmr_q;
        a_meas_d       = a_meas_q;
        a_meas_valid_d = a_meas_valid_q;
        timeout_c      = 1'b0;
        late_sof_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_enable) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // Wait for a blanking cycle so we never join mid-frame.
                if (!pre_frame_vsync) begin
                    state_d = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (sof_c) begin
                    state_d = ST_RUN;
                end else if (!cfg_enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (eof_c) begin
                    state_d = ST_WAIT_A;
                    tmr_d   = '0;
                end
            end
            ST_WAIT_A: begin
                if (a_done) begin
                    a_meas_d       = clamp_floor(a_result, A_MIN);
                    a_meas_valid_d = 1'b1;
                end
                if (sof_c) begin
                    // a_done in the SOF cycle is already captured above.
                    state_d    = ST_RUN;
                    late_sof_c = ~a_done;
                end else if (a_done) begin
                    state_d = cfg_enable ? ST_WAIT_SOF : ST_IDLE;
                end else if (tmr_q == TMR_W'(A_TIMEOUT - 1)) begin
                    timeout_c = 1'b1;
                    state_d   = cfg_enable ? ST_WAIT_SOF : ST_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-frame settings, counters and sticky flags.
    always_comb begin
        a_value_d   = a_value_q;
        bypass_d    = bypass_q;
        frame_cnt_d = frame_cnt_q + {15'd0, run_eof_c};
        geom_err_d  = (geom_err_q & ~err_clr) | geom_bad_c;
        a_to_d      = (a_to_q & ~err_clr) | timeout_c | late_sof_c;
        busy_d      = (state_d != ST_IDLE);
        if (enter_run_c) begin
            a_value_d = cfg_a_force    ? cfg_a_value :
                        a_meas_valid_d ? a_meas_d    : A_DEFAULT;
            bypass_d  = cfg_bypass;
        end
    end

    haze_frame_geom_chk #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_geom (
        .clk           (clk),
        .rst           (rst),
        .sof_i         (sof_c),
        .eof_i         (run_eof_c),
        .en_i          (gate_open_c),
        .href_i        (pre_frame_href),
        .clken_i       (pre_frame_clken),
        .frame_bad_c_o (geom_bad_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            vsync_q        <= 1'b0;
            tmr_q          <= '0;
            a_meas_q       <= '0;
            a_meas_valid_q <= 1'b0;
            a_value_q      <= A_DEFAULT;
            bypass_q       <= 1'b0;
            gate_vs_q      <= 1'b0;
            gate_hr_q      <= 1'b0;
            gate_ck_q      <= 1'b0;
            frame_cnt_q    <= '0;
            geom_err_q     <= 1'b0;
            a_to_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            vsync_q        <= pre_frame_vsync;
            tmr_q          <= tmr_d;
            a_meas_q       <= a_meas_d;
            a_meas_valid_q <= a_meas_valid_d;
            a_value_q      <= a_value_d;
            bypass_q       <= bypass_d;
            gate_vs_q      <= pre_frame_vsync & gate_open_c;
            gate_hr_q      <= pre_frame_href  & gate_open_c;
            gate_ck_q      <= pre_frame_clken & gate_open_c;
            frame_cnt_q    <= frame_cnt_d;
            geom_err_q     <= geom_err_d;
            a_to_q         <= a_to_d;
            busy_q         <= busy_d;
        end
    end

    assign gate_frame_vsync = gate_vs_q;
    assign gate_frame_href  = gate_hr_q;
    assign gate_frame_clken = gate_ck_q;
    assign a_value          = a_value_q;
    assign bypass_sel       = bypass_q;
    assign busy             = busy_q;
    assign frame_cnt        = frame_cnt_q;
    assign geom_err         = geom_err_q;
    assign a_timeout        = a_to_q;

endmodule
